// File: rtl/game_round_controller.sv
// game_round_controller: ByteBasher round sequencer (idle / pre-start countdown /
// timed play / pause / game over) with 1 Hz prescaler, BCD time-remaining and BCD score.
// Every output is registered and changes on the edge that samples its cause; no stalls.
//
// Ports:
//   ClockIn        system clock
//   Reset          synchronous active-high reset, overrides all other inputs
//   Start          pulse: start a round from IDLE or GAME_OVER
//   Pause          pulse: toggle PLAYING <-> PAUSED
//   Hit            pulse: valid whack, scored only while PLAYING
//   TimeOnes/Tens  BCD seconds remaining (pre-start count on ones, tens 0)
//   ScoreOnes/Tens BCD score, saturating at 99
//   State          0 IDLE, 1 PRESTART, 2 PLAYING, 3 PAUSED, 4 GAME_OVER
//   Playing        high exactly when State==PLAYING
//   GameOverPulse  one-cycle pulse on the first GAME_OVER cycle
module game_round_controller #(
  parameter int CLOCK_FREQUENCY  = 50000000,
  parameter int ROUND_SECONDS    = 60,
  parameter int PRESTART_SECONDS = 3
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Pause,
  input  logic       Hit,
  output logic [3:0] TimeOnes,
  output logic [3:0] TimeTens,
  output logic [3:0] ScoreOnes,
  output logic [3:0] ScoreTens,
  output logic [2:0] State,
  output logic       Playing,
  output logic       GameOverPulse
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESTART  = 3'd1,
    ST_PLAYING   = 3'd2,
    ST_PAUSED    = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  localparam int PW = (CLOCK_FREQUENCY > 2) ? $clog2(CLOCK_FREQUENCY) : 1;

  localparam logic [PW-1:0] PRE_RELOAD  = PW'(CLOCK_FREQUENCY - 1);
  localparam logic [3:0]    ROUND_TENS  = 4'(ROUND_SECONDS / 10);
  localparam logic [3:0]    ROUND_ONES  = 4'(ROUND_SECONDS % 10);
  localparam logic [3:0]    PRE_ONES    = 4'(PRESTART_SECONDS);

  state_t        state_q, state_d;
  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [3:0]    time_ones_q, time_ones_d;
  logic [3:0]    time_tens_q, time_tens_d;
  logic [3:0]    score_ones_q, score_ones_d;
  logic [3:0]    score_tens_q, score_tens_d;
  logic          playing_q, playing_d;
  logic          go_pulse_q, go_pulse_d;

  logic counting;
  logic tick;
  logic time_is_one;
  logic score_full;

  // The prescaler only runs while a second is actually being timed; in PAUSED it
  // is frozen so the partial second survives the pause.
  assign counting    = (state_q == ST_PRESTART) || (state_q == ST_PLAYING);
  assign tick        = counting && (prescaler_q == '0);
  assign time_is_one = (time_tens_q == 4'd0) && (time_ones_q == 4'd1);
  assign score_full  = (score_tens_q == 4'd9) && (score_ones_q == 4'd9);

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      prescaler_q  <= PRE_RELOAD;
      time_ones_q  <= ROUND_ONES;
      time_tens_q  <= ROUND_TENS;
      score_ones_q <= 4'd0;
      score_tens_q <= 4'd0;
      playing_q    <= 1'b0;
      go_pulse_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      prescaler_q  <= prescaler_d;
      time_ones_q  <= time_ones_d;
      time_tens_q  <= time_tens_d;
      score_ones_q <= score_ones_d;
      score_tens_q <= score_tens_d;
      playing_q    <= playing_d;
      go_pulse_q   <= go_pulse_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    prescaler_d  = prescaler_q;
    time_ones_d  = time_ones_q;
    time_tens_d  = time_tens_q;
    score_ones_d = score_ones_q;
    score_tens_d = score_tens_q;
    go_pulse_d   = 1'b0;

    if (counting) begin
      prescaler_d = tick ? PRE_RELOAD : (prescaler_q - 1'b1);
    end

    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (Start) begin
          state_d      = ST_PRESTART;
          prescaler_d  = PRE_RELOAD;
          time_ones_d  = PRE_ONES;
          time_tens_d  = 4'd0;
          score_ones_d = 4'd0;
          score_tens_d = 4'd0;
        end
      end

      ST_PRESTART: begin
        if (tick) begin
          if (time_ones_q <= 4'd1) begin
            // Last pre-start second expired: the round clock starts now.
            state_d     = ST_PLAYING;
            time_ones_d = ROUND_ONES;
            time_tens_d = ROUND_TENS;
          end else begin
            time_ones_d = time_ones_q - 4'd1;
          end
        end
      end

      ST_PLAYING: begin
        // A hit on the final-tick cycle still counts.
        if (Hit && !score_full) begin
          if (score_ones_q == 4'd9) begin
            score_ones_d = 4'd0;
            score_tens_d = score_tens_q + 4'd1;
          end else begin
            score_ones_d = score_ones_q + 4'd1;
          end
        end

        if (tick && time_is_one) begin
          // Game over takes priority over a simultaneous Pause.
          state_d     = ST_GAME_OVER;
          time_ones_d = 4'd0;
          time_tens_d = 4'd0;
          go_pulse_d  = 1'b1;
        end else begin
          if (tick) begin
            if (time_ones_q == 4'd0) begin
              time_ones_d = 4'd9;
              time_tens_d = time_tens_q - 4'd1;
            end else begin
              time_ones_d = time_ones_q - 4'd1;
            end
          end
          if (Pause) begin
            state_d = ST_PAUSED;
          end
        end
      end

      ST_PAUSED: begin
        if (Pause) begin
          state_d = ST_PLAYING;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered copy of the next state so Playing lines up with State.
    playing_d = (state_d == ST_PLAYING);
  end

  assign TimeOnes      = time_ones_q;
  assign TimeTens      = time_tens_q;
  assign ScoreOnes     = score_ones_q;
  assign ScoreTens     = score_tens_q;
  assign State         = state_q;
  assign Playing       = playing_q;
  assign GameOverPulse = go_pulse_q;

endmodule

// File: tb/tb_game_round_controller.sv
// tb_game_round_controller: directed checks of the round controller with a fast
// prescaler (4 cycles/second, 5 s round, 3 s pre-start) plus a 99 s instance for
// score saturation.
module tb_game_round_controller;

  logic       ClockIn = 1'b0;
  logic       Reset, Start, Pause, Hit;
  logic [3:0] TimeOnes, TimeTens, ScoreOnes, ScoreTens;
  logic [2:0] State;
  logic       Playing, GameOverPulse;

  logic       Start2, Pause2, Hit2;
  logic [3:0] TimeOnes2, TimeTens2, ScoreOnes2, ScoreTens2;
  logic [2:0] State2;
  logic       Playing2, GameOverPulse2;

  int n_checks = 0;
  int n_errors = 0;
  int n;

  always #5 ClockIn = ~ClockIn;

  game_round_controller #(
    .CLOCK_FREQUENCY(4), .ROUND_SECONDS(5), .PRESTART_SECONDS(3)
  ) u_dut (
    .ClockIn(ClockIn), .Reset(Reset), .Start(Start), .Pause(Pause), .Hit(Hit),
    .TimeOnes(TimeOnes), .TimeTens(TimeTens),
    .ScoreOnes(ScoreOnes), .ScoreTens(ScoreTens),
    .State(State), .Playing(Playing), .GameOverPulse(GameOverPulse)
  );

  game_round_controller #(
    .CLOCK_FREQUENCY(4), .ROUND_SECONDS(99), .PRESTART_SECONDS(3)
  ) u_dut99 (
    .ClockIn(ClockIn), .Reset(Reset), .Start(Start2), .Pause(Pause2), .Hit(Hit2),
    .TimeOnes(TimeOnes2), .TimeTens(TimeTens2),
    .ScoreOnes(ScoreOnes2), .ScoreTens(ScoreTens2),
    .State(State2), .Playing(Playing2), .GameOverPulse(GameOverPulse2)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  // Advance n cycles; outputs are looked at 1 time unit after the edge.
  task automatic cyc(input int cnt);
    repeat (cnt) begin
      @(posedge ClockIn);
      #1;
    end
  endtask

  function automatic int tm();
    return int'({TimeTens, TimeOnes});
  endfunction

  function automatic int sc();
    return int'({ScoreTens, ScoreOnes});
  endfunction

  initial begin
    Reset = 1'b1; Start = 1'b0; Pause = 1'b0; Hit = 1'b0;
    Start2 = 1'b0; Pause2 = 1'b0; Hit2 = 1'b0;
    cyc(2);
    Reset = 1'b0;

    // Reset state
    check("rst_state", State, 0);
    check("rst_time", tm(), 'h05);
    check("rst_score", sc(), 'h00);
    check("rst_playing", Playing, 0);
    check("rst_gop", GameOverPulse, 0);
    check("rst_time99", int'({TimeTens2, TimeOnes2}), 'h99);

    // Hits in IDLE are ignored
    Hit = 1'b1; cyc(5); Hit = 1'b0;
    check("idle_hit_score", sc(), 'h00);
    check("idle_hit_state", State, 0);

    // Start -> pre-start countdown 3,2,1 then PLAYING with 05
    Start = 1'b1; cyc(1); Start = 1'b0;          // T+1
    check("pre_state", State, 1);
    check("pre_t3", tm(), 'h03);
    Hit = 1'b1; cyc(4); Hit = 1'b0;              // T+5, hits ignored in pre-start
    check("pre_t2", tm(), 'h02);
    check("pre_hit_score", sc(), 'h00);
    cyc(4);                                      // T+9
    check("pre_t1", tm(), 'h01);
    check("pre_state2", State, 1);
    cyc(4);                                      // T+13 = P
    check("play_state", State, 2);
    check("play_time", tm(), 'h05);
    check("play_playing", Playing, 1);

    // Uninterrupted round, Hit coincident with the final tick
    cyc(4);  check("r1_t4", tm(), 'h04);         // P+4
    cyc(4);  check("r1_t3", tm(), 'h03);         // P+8
    cyc(8);  check("r1_t1", tm(), 'h01);         // P+16
    cyc(3);                                      // P+19
    check("r1_p19_state", State, 2);
    check("r1_p19_gop", GameOverPulse, 0);
    Hit = 1'b1; cyc(1); Hit = 1'b0;              // P+20
    check("r1_go_time", tm(), 'h00);
    check("r1_go_state", State, 4);
    check("r1_go_pulse", GameOverPulse, 1);
    check("r1_go_score", sc(), 'h01);
    check("r1_go_playing", Playing, 0);
    cyc(1);
    check("r1_pulse_once", GameOverPulse, 0);
    check("r1_go_hold", State, 4);
    Hit = 1'b1; cyc(3); Hit = 1'b0;
    check("go_hit_score", sc(), 'h01);
    check("go_time_hold", tm(), 'h00);

    // Start from GAME_OVER clears score
    Start = 1'b1; cyc(1); Start = 1'b0;
    check("restart_state", State, 1);
    check("restart_score", sc(), 'h00);
    check("restart_time", tm(), 'h03);
    cyc(12);                                     // P
    check("r2_state", State, 2);

    // Round 2: two hits, pause once time reads 3, hold 50 cycles
    Hit = 1'b1; cyc(2); Hit = 1'b0;              // P+2
    check("r2_score", sc(), 'h02);
    cyc(6);                                      // P+8
    check("r2_t3", tm(), 'h03);
    Pause = 1'b1; cyc(1); Pause = 1'b0;          // P+9: 9 playing cycles used
    check("pause_state", State, 3);
    check("pause_playing", Playing, 0);
    Hit = 1'b1; cyc(5); Hit = 1'b0;
    check("pause_hit_score", sc(), 'h02);
    cyc(20);
    check("pause_mid_time", tm(), 'h03);
    check("pause_mid_state", State, 3);
    cyc(25);                                     // 50 cycles in PAUSED
    check("pause_end_time", tm(), 'h03);
    check("pause_end_state", State, 3);
    Pause = 1'b1; cyc(1); Pause = 1'b0;
    check("resume_state", State, 2);
    n = 0;
    while (State != 3'd4 && n < 100) begin
      cyc(1);
      n++;
    end
    // 20 playing cycles in total, 9 spent before the pause
    check("resume_go_cycles", n, 11);
    check("resume_go_time", tm(), 'h00);

    // Round 3: reset mid-round
    Start = 1'b1; cyc(1); Start = 1'b0;
    cyc(12);                                     // P
    check("r3_state", State, 2);
    Hit = 1'b1; cyc(1); Hit = 1'b0;              // P+1
    check("r3_score", sc(), 'h01);
    cyc(9);                                      // P+10
    check("r3_p10_time", tm(), 'h03);
    Reset = 1'b1; cyc(1); Reset = 1'b0;
    check("mid_rst_state", State, 0);
    check("mid_rst_time", tm(), 'h05);
    check("mid_rst_score", sc(), 'h00);
    check("mid_rst_playing", Playing, 0);

    // 99-second instance: BCD wrap and score saturation
    Start2 = 1'b1; cyc(1); Start2 = 1'b0;
    cyc(12);
    check("s99_state", State2, 2);
    check("s99_time", int'({TimeTens2, TimeOnes2}), 'h99);
    Hit2 = 1'b1; cyc(10);
    check("s99_score10", int'({ScoreTens2, ScoreOnes2}), 'h10);
    cyc(91); Hit2 = 1'b0;                        // 101 hits total
    check("s99_score_sat", int'({ScoreTens2, ScoreOnes2}), 'h99);
    check("s99_time_after", int'({TimeTens2, TimeOnes2}), 'h74);
    check("s99_still_playing", State2, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
